fixed_point_abs_vec: RTL and testbench
======================================

// Module: fixed_point_abs_vec
//
// PURPOSE
//   Multi-lane, pipelined fixed-point absolute value / negate unit with a valid/ready stream handshake.
//   Each transfer carries NUM_CH signed lanes and a per-transfer operation mode. The most-negative
//   value is handled by saturation or wrap, and per-lane overflow flags are reported with each result.
//   A saturating overflow event counter is kept for debug. Sits between fixed-point datapath stages
//   (e.g. after FIXED_POINT_ADD / MUL trees, ahead of comparators or norm accumulators).
//
// PARAMETERS
//   WIDTH       8   Lane width in bits, signed two's complement (>= 2)
//   FRAC_BITS   3   Fractional bits; carried for format consistency only, no effect on arithmetic
//   NUM_CH      4   Number of lanes per transfer (>= 1)
//   SATURATE    1   1: out-of-range result clamps to +MAX; 0: result wraps (stays -2^(WIDTH-1))
//   CNT_WIDTH   16  Width of the overflow event counter
//
// PORTS
//   CLK        in   1               Clock, all logic on rising edge
//   RSTN       in   1               Synchronous reset, active low
//   DATA_IN    in   NUM_CH*WIDTH    Input lanes; lane i = DATA_IN[i*WIDTH +: WIDTH]
//   MODE_IN    in   2               Operation: 00 pass, 01 abs, 10 negate, 11 negative-abs (-|x|)
//   VALID_IN   in   1               Input beat valid
//   READY_IN   out  1               Unit can accept a beat this cycle
//   DATA_OUT   out  NUM_CH*WIDTH    Result lanes, same packing as DATA_IN
//   OVF_OUT    out  NUM_CH          Per-lane overflow flag, qualified by VALID_OUT
//   VALID_OUT  out  1               Output beat valid
//   READY_OUT  in   1               Downstream accepts the beat
//   CLEAR_IN   in   1               Synchronous clear of OVF_COUNT
//   OVF_COUNT  out  CNT_WIDTH       Number of delivered beats with any OVF_OUT bit set, saturating
//
// BEHAVIOUR
//   - Reset (RSTN=0 at clock edge): both stage valids, VALID_OUT, OVF_OUT, DATA_OUT and OVF_COUNT go to 0.
//     READY_IN reads 1 in the first cycle after reset. A reset mid-stream discards all in-flight beats.
//   - Pipeline: S1 registers DATA_IN/MODE_IN; S2 computes and registers DATA_OUT/OVF_OUT.
//     A beat is accepted when VALID_IN && READY_IN. With no stall, VALID_OUT rises 2 cycles after acceptance.
//   - Flow: S2 loads when !VALID_OUT || READY_OUT. S1 loads when S1 is empty or S1 moves into S2.
//     READY_IN = !s1_valid || !VALID_OUT || READY_OUT (combinational from READY_OUT).
//     Throughput is 1 beat/cycle. No beat is dropped or duplicated.
//   - DATA_OUT, OVF_OUT and VALID_OUT hold stable while VALID_OUT && !READY_OUT.
//   - Lane arithmetic (MIN = -2^(WIDTH-1), MAX = 2^(WIDTH-1)-1), result r for input x:
//       00: r = x, ovf = 0
//       01: r = (x<0) ? -x : x, ovf = (x==MIN)
//       10: r = -x, ovf = (x==MIN)
//       11: r = (x>0) ? -x : x, ovf = 0 (always representable)
//     When ovf=1: SATURATE=1 gives r = MAX; SATURATE=0 gives r = MIN (two's complement wrap).
//     Negation is ~x + 1 in WIDTH bits. Lanes are fully independent.
//   - OVF_COUNT increments by 1 on each output handshake (VALID_OUT && READY_OUT) with |OVF_OUT.
//     It holds at 2^CNT_WIDTH-1 once reached (no wrap).
//     CLEAR_IN forces 0 on that edge; CLEAR_IN wins over a simultaneous increment.
//
// TESTING
//   1 WIDTH=8, NUM_CH=4, mode 01, lanes {-5,7,0,-1} (0xFB,0x07,0x00,0xFF), READY_OUT=1
//     -> 2 cycles later DATA_OUT lanes {5,7,0,1}, OVF_OUT=0000.
//   2 Mode 01, lane0 = 0x80, SATURATE=1 -> lane0 = 0x7F, OVF_OUT[0]=1, OVF_COUNT 0->1;
//     same with SATURATE=0 -> lane0 = 0x80, OVF_OUT[0]=1.
//   3 Modes 10 and 11 on {3,-3,0x80,0} -> mode 10: {-3,3,0x7F sat,0} with ovf on lane2;
//     mode 11: {-3,-3,0x80,0} with no ovf.
//   4 Stream 16 beats back-to-back, toggle READY_OUT randomly -> outputs in order, no loss/dup,
//     DATA_OUT stable while stalled, READY_IN=0 only when both stages full and READY_OUT=0.
//   5 CNT_WIDTH=2, 5 overflow beats -> OVF_COUNT saturates at 3;
//     CLEAR_IN coincident with an overflow handshake -> OVF_COUNT=0.
//   6 Assert RSTN=0 with 2 beats in flight -> next cycle VALID_OUT=0, OVF_COUNT=0, READY_IN=1,
//     no stale beat emerges afterwards.

Source files
------------

// File: rtl/fixed_point_abs_vec.sv
// Multi-lane pipelined fixed-point abs/negate unit with valid/ready handshake,
// per-lane overflow flags and a saturating overflow event counter.
module fixed_point_abs_vec #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAC_BITS = 3,
  parameter int unsigned NUM_CH    = 4,
  parameter bit          SATURATE  = 1'b1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic [NUM_CH*WIDTH-1:0] DATA_IN,
  input  logic [1:0]              MODE_IN,
  input  logic                    VALID_IN,
  output logic                    READY_IN,
  output logic [NUM_CH*WIDTH-1:0] DATA_OUT,
  output logic [NUM_CH-1:0]       OVF_OUT,
  output logic                    VALID_OUT,
  input  logic                    READY_OUT,
  input  logic                    CLEAR_IN,
  output logic [CNT_WIDTH-1:0]    OVF_COUNT
);

  localparam int unsigned BUS_W = NUM_CH * WIDTH;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL = ~MIN_VAL;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Fractional position does not affect the arithmetic; kept for format bookkeeping.
  logic unused_frac;
  assign unused_frac = (FRAC_BITS > WIDTH);

  logic             s1_valid;
  logic [BUS_W-1:0] s1_data;
  logic [1:0]       s1_mode;
  logic             s2_load;
  logic [BUS_W-1:0] calc_data;
  logic [NUM_CH-1:0] calc_ovf;

  // Returns {ovf, result} for one lane.
  function automatic logic [WIDTH:0] lane_op(input logic [WIDTH-1:0] x, input logic [1:0] mode);
    logic [WIDTH-1:0] neg;
    logic [WIDTH-1:0] r;
    logic             ovf;
    logic             is_min;
    logic             is_pos;
    neg    = ~x + WIDTH'(1);
    is_min = (x == MIN_VAL);
    is_pos = !x[WIDTH-1] && (x != '0);
    r      = x;
    ovf    = 1'b0;
    case (mode)
      2'b00: begin
        r   = x;
        ovf = 1'b0;
      end
      2'b01: begin
        r   = x[WIDTH-1] ? neg : x;
        ovf = is_min;
      end
      2'b10: begin
        r   = neg;
        ovf = is_min;
      end
      2'b11: begin
        r   = is_pos ? neg : x;
        ovf = 1'b0;
      end
    endcase
    if (ovf) r = SATURATE ? MAX_VAL : MIN_VAL;
    return {ovf, r};
  endfunction

  always_comb begin
    calc_data = '0;
    calc_ovf  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      {calc_ovf[i], calc_data[i*WIDTH +: WIDTH]} = lane_op(s1_data[i*WIDTH +: WIDTH], s1_mode);
    end
  end

  assign s2_load  = !VALID_OUT || READY_OUT;
  assign READY_IN = !s1_valid || s2_load;

  // Two-stage skid-free pipe: S1 captures inputs, S2 holds the computed result.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_mode   <= '0;
      VALID_OUT <= 1'b0;
      DATA_OUT  <= '0;
      OVF_OUT   <= '0;
    end else begin
      if (READY_IN) begin
        s1_valid <= VALID_IN;
        if (VALID_IN) begin
          s1_data <= DATA_IN;
          s1_mode <= MODE_IN;
        end
      end
      if (s2_load) begin
        VALID_OUT <= s1_valid;
        if (s1_valid) begin
          DATA_OUT <= calc_data;
          OVF_OUT  <= calc_ovf;
        end
      end
    end
  end

  // Counts delivered beats carrying any overflow; clear has priority, no wrap.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      OVF_COUNT <= '0;
    end else if (CLEAR_IN) begin
      OVF_COUNT <= '0;
    end else if (VALID_OUT && READY_OUT && (|OVF_OUT) && (OVF_COUNT != CNT_MAX)) begin
      OVF_COUNT <= OVF_COUNT + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fixed_point_abs_vec.sv
// Bench for fixed_point_abs_vec: saturating and wrapping instances driven in lockstep,
// checked against an integer-arithmetic reference model and a beat scoreboard.
module tb_fixed_point_abs_vec;

  logic        CLK;
  logic        RSTN;
  logic [31:0] DATA_IN;
  logic [1:0]  MODE_IN;
  logic        VALID_IN;
  logic        READY_OUT;
  logic        CLEAR_IN;

  logic        ready_a, ready_b;
  logic [31:0] data_a, data_b;
  logic [3:0]  ovf_a, ovf_b;
  logic        valid_a, valid_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  fixed_point_abs_vec #(.WIDTH(8), .FRAC_BITS(3), .NUM_CH(4), .SATURATE(1'b1), .CNT_WIDTH(16)) dut_sat (
    .CLK(CLK), .RSTN(RSTN), .DATA_IN(DATA_IN), .MODE_IN(MODE_IN), .VALID_IN(VALID_IN),
    .READY_IN(ready_a), .DATA_OUT(data_a), .OVF_OUT(ovf_a), .VALID_OUT(valid_a),
    .READY_OUT(READY_OUT), .CLEAR_IN(CLEAR_IN), .OVF_COUNT(cnt_a));

  fixed_point_abs_vec #(.WIDTH(8), .FRAC_BITS(3), .NUM_CH(4), .SATURATE(1'b0), .CNT_WIDTH(2)) dut_wrap (
    .CLK(CLK), .RSTN(RSTN), .DATA_IN(DATA_IN), .MODE_IN(MODE_IN), .VALID_IN(VALID_IN),
    .READY_IN(ready_b), .DATA_OUT(data_b), .OVF_OUT(ovf_b), .VALID_OUT(valid_b),
    .READY_OUT(READY_OUT), .CLEAR_IN(CLEAR_IN), .OVF_COUNT(cnt_b));

  typedef struct {
    logic [31:0] da;
    logic [31:0] db;
    logic [3:0]  ovf;
  } beat_t;

  typedef struct {
    logic [31:0] din;
    logic [1:0]  mode;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [3:0]  exp_ovf;
  } vec_t;

  int    checks;
  int    errors;
  beat_t exp_q[$];
  int    cnt_a_m;
  int    cnt_b_m;
  logic  stall_prev;
  logic [31:0] held_da, held_db;
  logic [3:0]  held_ovf;
  vec_t  vecs[7];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: lanes as integers, overflow when the true result exceeds +127.
  function automatic beat_t model(input logic [31:0] din, input logic [1:0] mode);
    beat_t b;
    int    x;
    int    r;
    b.da  = '0;
    b.db  = '0;
    b.ovf = '0;
    for (int i = 0; i < 4; i++) begin
      x = 32'($signed(din[i*8 +: 8]));
      case (mode)
        2'd0:    r = x;
        2'd1:    r = (x < 0) ? -x : x;
        2'd2:    r = -x;
        default: r = (x > 0) ? -x : x;
      endcase
      if (r > 127) begin
        b.ovf[i]       = 1'b1;
        b.da[i*8 +: 8] = 8'h7F;
        b.db[i*8 +: 8] = 8'h80;
      end else begin
        b.da[i*8 +: 8] = 8'(r);
        b.db[i*8 +: 8] = 8'(r);
      end
    end
    return b;
  endfunction

  task automatic cycle(input logic [31:0] d, input logic [1:0] m, input logic v,
                       input logic ro, input logic clr);
    beat_t b;
    logic  exp_rdy;
    DATA_IN   = d;
    MODE_IN   = m;
    VALID_IN  = v;
    READY_OUT = ro;
    CLEAR_IN  = clr;
    #1;
    exp_rdy = !(exp_q.size() == 2 && !ro);
    if (stall_prev) begin
      chk("stall_valid", 64'(valid_a), 64'(1));
      chk("stall_data_sat", 64'(data_a), 64'(held_da));
      chk("stall_data_wrap", 64'(data_b), 64'(held_db));
      chk("stall_ovf", 64'(ovf_a), 64'(held_ovf));
    end
    chk("ready_in_sat", 64'(ready_a), 64'(exp_rdy));
    chk("ready_in_wrap", 64'(ready_b), 64'(exp_rdy));
    if (valid_a && ro) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        chk("valid_wrap", 64'(valid_b), 64'(1));
        chk("data_sat", 64'(data_a), 64'(b.da));
        chk("data_wrap", 64'(data_b), 64'(b.db));
        chk("ovf_sat", 64'(ovf_a), 64'(b.ovf));
        chk("ovf_wrap", 64'(ovf_b), 64'(b.ovf));
        if (|b.ovf) begin
          if (cnt_a_m < 65535) cnt_a_m++;
          if (cnt_b_m < 3) cnt_b_m++;
        end
      end
    end
    if (clr) begin
      cnt_a_m = 0;
      cnt_b_m = 0;
    end
    if (v && exp_rdy) exp_q.push_back(model(d, m));
    stall_prev = valid_a && !ro;
    held_da    = data_a;
    held_db    = data_b;
    held_ovf   = ovf_a;
    @(posedge CLK);
    #1;
    chk("ovf_count_sat", 64'(cnt_a), 64'(cnt_a_m));
    chk("ovf_count_wrap", 64'(cnt_b), 64'(cnt_b_m));
  endtask

  task automatic do_reset();
    RSTN      = 1'b0;
    VALID_IN  = 1'b0;
    READY_OUT = 1'b1;
    CLEAR_IN  = 1'b0;
    DATA_IN   = '0;
    MODE_IN   = '0;
    @(posedge CLK);
    #1;
    exp_q.delete();
    cnt_a_m    = 0;
    cnt_b_m    = 0;
    stall_prev = 1'b0;
    chk("rst_valid_sat", 64'(valid_a), 64'(0));
    chk("rst_valid_wrap", 64'(valid_b), 64'(0));
    chk("rst_data", 64'(data_a), 64'(0));
    chk("rst_ovf", 64'(ovf_a), 64'(0));
    chk("rst_count_sat", 64'(cnt_a), 64'(0));
    chk("rst_count_wrap", 64'(cnt_b), 64'(0));
    chk("rst_ready_in", 64'(ready_a), 64'(1));
    RSTN = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    checks = 0;
    errors = 0;
    cnt_a_m = 0;
    cnt_b_m = 0;
    stall_prev = 1'b0;
    held_da = '0;
    held_db = '0;
    held_ovf = '0;

    // Lane 0 is the least significant byte.
    vecs[0] = '{32'hFF0007FB, 2'b01, 32'h01000705, 32'h01000705, 4'b0000};
    vecs[1] = '{32'h01F01080, 2'b01, 32'h0110107F, 32'h01101080, 4'b0001};
    vecs[2] = '{32'h0080FD03, 2'b10, 32'h007F03FD, 32'h008003FD, 4'b0100};
    vecs[3] = '{32'h0080FD03, 2'b11, 32'h0080FDFD, 32'h0080FDFD, 4'b0000};
    vecs[4] = '{32'h807F01FF, 2'b00, 32'h807F01FF, 32'h807F01FF, 4'b0000};
    vecs[5] = '{32'h817F01FF, 2'b01, 32'h7F7F0101, 32'h7F7F0101, 4'b0000};
    vecs[6] = '{32'h7F010500, 2'b11, 32'h81FFFB00, 32'h81FFFB00, 4'b0000};

    do_reset();

    // Directed vectors with latency check: result appears exactly two cycles after acceptance.
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].din, vecs[i].mode, 1'b1, 1'b1, 1'b0);
      chk("lat1_valid", 64'(valid_a), 64'(0));
      cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
      chk("lat2_valid", 64'(valid_a), 64'(1));
      chk("vec_data_sat", 64'(data_a), 64'(vecs[i].exp_a));
      chk("vec_data_wrap", 64'(data_b), 64'(vecs[i].exp_b));
      chk("vec_ovf_sat", 64'(ovf_a), 64'(vecs[i].exp_ovf));
      chk("vec_ovf_wrap", 64'(ovf_b), 64'(vecs[i].exp_ovf));
      cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    end
    chk("count_after_vectors", 64'(cnt_a), 64'(2));

    // Counter saturation on the 2-bit instance, then clear colliding with an overflow handshake.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(32'h00000080, 2'b01, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("sat_count_wrap", 64'(cnt_b), 64'(3));
    chk("sat_count_sat", 64'(cnt_a), 64'(5));
    cycle(32'h00800000, 2'b10, 1'b1, 1'b1, 1'b0);
    cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("clr_beat_valid", 64'(valid_a), 64'(1));
    cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("clr_wins_sat", 64'(cnt_a), 64'(0));
    chk("clr_wins_wrap", 64'(cnt_b), 64'(0));

    // Random stream with random backpressure and occasional clears.
    for (int n = 0; n < 400; n++) begin
      d = $urandom;
      for (int l = 0; l < 4; l++) if ($urandom_range(0, 5) == 0) d[l*8 +: 8] = 8'h80;
      cycle(d, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    for (int n = 0; n < 8 && exp_q.size() != 0; n++) cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    // Reset with two overflow beats in flight: nothing stale may emerge.
    cycle(32'h80000000, 2'b01, 1'b1, 1'b1, 1'b0);
    cycle(32'h00000080, 2'b10, 1'b1, 1'b1, 1'b0);
    cycle(32'h00008000, 2'b01, 1'b1, 1'b1, 1'b0);
    chk("inflight_before_reset", 64'(exp_q.size()), 64'(2));
    do_reset();
    for (int n = 0; n < 6; n++) cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("post_reset_valid", 64'(valid_a), 64'(0));
    chk("post_reset_count", 64'(cnt_a), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
